// File: rtl/host_mem_sequencer.sv
// Host-side command sequencer driving top_control's external-access ports.
// Optional HOST_SEQ_CHECKSUM_EN adds a running sum of all streamed words.
module host_mem_sequencer #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned WR_CYCLES = 4,
  parameter int unsigned RD_LAT    = 5,
  parameter int unsigned RUN_MAX   = 120000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              proc_done,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              start,
  output logic              start_2,
  output logic              start_3,
  output logic              start_4,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              iram_write_ext,
  output logic              dram_write_ext,
  output logic              read_en_ext,
  output logic [DATA_W-1:0] Data_in_ins,
  output logic [DATA_W-1:0] Data_in_dram,
  input  logic [DATA_W-1:0] dram_in,
  output logic [DATA_W-1:0] checksum
);
  localparam int unsigned CYC_MAX = (WR_CYCLES > RD_LAT) ? WR_CYCLES : RD_LAT;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned RUN_W   = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;

  localparam logic [1:0] OP_LOAD_IRAM = 2'b00;
  localparam logic [1:0] OP_LOAD_DRAM = 2'b01;
  localparam logic [1:0] OP_RUN       = 2'b10;
  localparam logic [1:0] OP_READBACK  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_WDATA, S_WSETUP, S_WPULSE, S_WHOLD,
    S_RSETUP, S_RWAIT, S_RPUSH, S_RUN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d, cnt_q, cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] ins_q, ins_d, drm_q, drm_d, rdat_q, rdat_d;
  logic              timeout_q, timeout_d;
  logic              cmd_ready_q, busy_q, done_q, wr_ready_q, rd_valid_q;
  logic              start_q, start_2_q, start_3_q, start_4_q;
  logic              iram_we_q, dram_we_q, rd_en_q;
  logic              accept, last_word;

  assign accept    = cmd_valid && cmd_ready_q;
  assign last_word = (cnt_q + ADDR_W'(1)) == len_q;

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    run_d     = run_q;
    ins_d     = ins_q;
    drm_d     = drm_q;
    rdat_d    = rdat_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = cmd_op;
          addr_d    = cmd_base;
          len_d     = cmd_len;
          cnt_d     = '0;
          run_d     = '0;
          timeout_d = 1'b0;
          if (cmd_op == OP_RUN)          state_d = S_RUN;
          else if (cmd_len == '0)        state_d = S_DONE;
          else if (cmd_op == OP_READBACK) state_d = S_RSETUP;
          else                           state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        if (wr_valid) begin
          if (op_q == OP_LOAD_IRAM) ins_d = wr_data;
          else                      drm_d = wr_data;
          state_d = S_WSETUP;
        end
      end
      S_WSETUP: begin
        cyc_d   = '0;
        state_d = S_WPULSE;
      end
      S_WPULSE: begin
        if (cyc_q == CYC_W'(WR_CYCLES - 1)) state_d = S_WHOLD;
        else                                cyc_d   = cyc_q + CYC_W'(1);
      end
      S_WHOLD: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + ADDR_W'(1);
        state_d = last_word ? S_DONE : S_WDATA;
      end
      S_RSETUP: begin
        cyc_d   = '0;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (cyc_q == CYC_W'(RD_LAT - 1)) begin
          rdat_d  = dram_in;
          state_d = S_RPUSH;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_RPUSH: begin
        if (rd_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = last_word ? S_DONE : S_RSETUP;
        end
      end
      S_RUN: begin
        // proc_done takes priority over an expiring run budget
        if (proc_done) begin
          state_d = S_DONE;
        end else if (run_q == RUN_W'(RUN_MAX - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered state, datapath and strobes (strobes follow the next state)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      run_q       <= '0;
      ins_q       <= '0;
      drm_q       <= '0;
      rdat_q      <= '0;
      timeout_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      start_q     <= 1'b0;
      start_2_q   <= 1'b0;
      start_3_q   <= 1'b0;
      start_4_q   <= 1'b0;
      iram_we_q   <= 1'b0;
      dram_we_q   <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      run_q       <= run_d;
      ins_q       <= ins_d;
      drm_q       <= drm_d;
      rdat_q      <= rdat_d;
      timeout_q   <= timeout_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      wr_ready_q  <= (state_d == S_WDATA);
      rd_valid_q  <= (state_d == S_RPUSH);
      start_q     <= (state_d != S_IDLE) && (op_d == OP_RUN);
      start_2_q   <= (state_d != S_IDLE) && (op_d == OP_LOAD_IRAM);
      start_3_q   <= (state_d != S_IDLE) && (op_d == OP_LOAD_DRAM);
      start_4_q   <= (state_d != S_IDLE) && (op_d == OP_READBACK);
      iram_we_q   <= (state_d == S_WPULSE) && (op_d == OP_LOAD_IRAM);
      dram_we_q   <= (state_d == S_WPULSE) && (op_d == OP_LOAD_DRAM);
      rd_en_q     <= (state_d == S_RWAIT);
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign wr_ready       = wr_ready_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rdat_q;
  assign start          = start_q;
  assign start_2        = start_2_q;
  assign start_3        = start_3_q;
  assign start_4        = start_4_q;
  assign addr_ext       = addr_q;
  assign iram_write_ext = iram_we_q;
  assign dram_write_ext = dram_we_q;
  assign read_en_ext    = rd_en_q;
  assign Data_in_ins    = ins_q;
  assign Data_in_dram   = drm_q;

`ifdef HOST_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // Wrapping sum of every word handed over on either stream
  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE && accept)          sum_d = '0;
    else if (state_q == S_WDATA && wr_valid)  sum_d = sum_q + wr_data;
    else if (state_q == S_RPUSH && rd_ready)  sum_d = sum_q + rdat_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
